// File: rtl/register_pkg.sv
// Shared constants and state encoding for the register stage and its serializer.
package register_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 64;
  localparam int unsigned GAP_CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_e;

endpackage

// File: rtl/register_serializer_if.sv
// Upstream valid/ready word handshake plus framed bit-serial output of the serializer.
interface register_serializer_if
  import register_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

  logic signed [DATA_WIDTH-1:0] input_port;
  logic                         in_valid;
  logic                         in_ready;
  logic                         ser_out;
  logic                         ser_frame;
  logic                         ser_last;
  logic                         busy;

  modport master (
    output input_port, in_valid,
    input  in_ready, ser_out, ser_frame, ser_last, busy
  );

  modport slave (
    input  input_port, in_valid,
    output in_ready, ser_out, ser_frame, ser_last, busy
  );

endinterface

// File: rtl/register_serializer.sv
// Parallel-in, serial-out transmitter: one framed bit per clock, optional idle gap between words.
module register_serializer
  import register_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  register_serializer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  typedef logic [DATA_WIDTH-1:0] word_t;

  function automatic logic head_bit(input word_t w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic word_t shift_out(input word_t w);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  ser_state_e           state_q, state_d;
  word_t                sreg_q, sreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [GAP_CNT_W-1:0] gap_q, gap_d;
  logic                 out_q, out_d;
  logic                 frame_q, frame_d;
  logic                 last_q, last_d;
  logic                 in_ready;
  logic                 accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      out_q   <= 1'b0;
      frame_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      out_q   <= out_d;
      frame_q <= frame_d;
      last_q  <= last_d;
    end
  end

  // The head bit is emitted on the load edge itself, so the shift register only holds
  // the bits still to go; the counter tracks the bit currently on the line.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    out_d   = 1'b0;
    frame_d = 1'b0;
    last_d  = 1'b0;
    accept  = bus.in_valid && in_ready;

    if (accept) begin
      state_d = SHIFT;
      sreg_d  = shift_out(bus.input_port);
      cnt_d   = CNT_W'(DATA_WIDTH - 1);
      out_d   = head_bit(bus.input_port);
      frame_d = 1'b1;
    end else begin
      unique case (state_q)
        SHIFT: begin
          if (cnt_q != '0) begin
            sreg_d  = shift_out(sreg_q);
            cnt_d   = cnt_q - CNT_W'(1);
            out_d   = head_bit(sreg_q);
            frame_d = 1'b1;
            last_d  = (cnt_q == CNT_W'(1));
          end else if (GAP_CYCLES != 0) begin
            state_d = GAP;
            gap_d   = GAP_CNT_W'(GAP_CYCLES - 1);
          end else begin
            state_d = IDLE;
          end
        end
        GAP: begin
          if (gap_q == '0) state_d = IDLE;
          else             gap_d   = gap_q - GAP_CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready      = (state_q == IDLE) ||
                    ((GAP_CYCLES == 0) && (state_q == SHIFT) && (cnt_q == '0));
    bus.in_ready  = in_ready;
    bus.busy      = (state_q != IDLE);
    bus.ser_out   = out_q;
    bus.ser_frame = frame_q;
    bus.ser_last  = last_q;
  end

endmodule

// File: tb/tb_register_serializer.sv
// Scoreboard bench: three serializer variants checked against a cycle-timing model and reassembled words.
module tb_register_serializer;
  import register_pkg::*;

  localparam int DW = 64;
  localparam bit MSBF [3] = '{1'b1, 1'b0, 1'b1};
  localparam int GAPC [3] = '{1, 3, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          vld  [3];
  logic [DW-1:0] dat  [3];
  logic          rdy  [3];
  logic          frm  [3];
  logic          sout [3];
  logic          lst  [3];
  logic          bsy  [3];

  register_serializer_if #(.DATA_WIDTH(DW)) if0 ();
  register_serializer_if #(.DATA_WIDTH(DW)) if1 ();
  register_serializer_if #(.DATA_WIDTH(DW)) if2 ();

  register_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1), .GAP_CYCLES(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  register_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0), .GAP_CYCLES(3)) u1 (.clk(clk), .rst(rst), .bus(if1));
  register_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.in_valid = vld[0];  assign if0.input_port = dat[0];
  assign if1.in_valid = vld[1];  assign if1.input_port = dat[1];
  assign if2.in_valid = vld[2];  assign if2.input_port = dat[2];
  assign rdy[0] = if0.in_ready;  assign frm[0] = if0.ser_frame;  assign sout[0] = if0.ser_out;
  assign lst[0] = if0.ser_last;  assign bsy[0] = if0.busy;
  assign rdy[1] = if1.in_ready;  assign frm[1] = if1.ser_frame;  assign sout[1] = if1.ser_out;
  assign lst[1] = if1.ser_last;  assign bsy[1] = if1.busy;
  assign rdy[2] = if2.in_ready;  assign frm[2] = if2.ser_frame;  assign sout[2] = if2.ser_out;
  assign lst[2] = if2.ser_last;  assign bsy[2] = if2.busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input int i, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, i, cyc, act, exp);
    end
  endtask

  // Reference model: a word accepted at cycle a occupies the line for cycles a+1..a+DW,
  // then GAPC idle cycles, then one IDLE accept cycle (none of that when GAPC is 0).
  bit            armed = 1'b0;
  bit            has   [3];
  int            acc_t [3];
  logic [DW-1:0] sbq   [3][$];
  logic [DW-1:0] cap   [3];
  int            nb    [3];
  int            d;
  bit            ef, el, er, eb;

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (armed) begin
        d  = cyc - acc_t[i];
        ef = has[i] && d >= 1 && d <= DW;
        el = has[i] && d == DW;
        er = !has[i] || d >= ((GAPC[i] == 0) ? DW : DW + GAPC[i] + 1);
        eb = has[i] && d <= DW + GAPC[i];
        chk("in_ready",  i, rdy[i], er);
        chk("ser_frame", i, frm[i], ef);
        chk("ser_last",  i, lst[i], el);
        chk("busy",      i, bsy[i], eb);
        if (!frm[i]) begin
          chk("ser_out_idle", i, sout[i], 1'b0);
        end else begin
          if (MSBF[i]) cap[i] = {cap[i][DW-2:0], sout[i]};
          else         cap[i] = {sout[i], cap[i][DW-1:1]};
          nb[i]++;
          if (lst[i]) begin
            chk("bit_count", i, nb[i], DW);
            if (sbq[i].size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL word_unexpected dut%0d cyc %0d: got %h expected none", i, cyc, cap[i]);
            end else begin
              chk("word", i, cap[i], sbq[i].pop_front());
            end
            nb[i] = 0;
          end
        end
        if (rst) begin
          has[i] = 1'b0;
          sbq[i].delete();
          nb[i]  = 0;
        end else if (vld[i] && er) begin
          has[i]   = 1'b1;
          acc_t[i] = cyc;
          sbq[i].push_back(dat[i]);
        end
      end
    end
    if (rst) armed = 1'b1;
  end

  task automatic send(input int i, input logic [DW-1:0] w);
    bit done = 1'b0;
    vld[i] = 1'b1;
    dat[i] = w;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clk);
      if (rdy[i] && !rst) begin
        @(posedge clk);
        #1;
        vld[i] = 1'b0;
        dat[i] = {$urandom, $urandom};
        done   = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout dut%0d cyc %0d: got no handshake expected handshake", i, cyc);
      vld[i] = 1'b0;
    end
  endtask

  task automatic rand_run(input int i);
    for (int k = 0; k < 15; k++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      send(i, {$urandom, $urandom});
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      dat[i] = '0;
      nb[i]  = 0;
      cap[i] = '0;
      has[i] = 1'b0;
      acc_t[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    fork
      begin send(0, 64'hDB6DB6DB6DB6DB6D); send(0, 64'h0123456789ABCDEF); end
      begin send(1, 64'h0000000000000001); send(1, 64'h8000000000000001); end
      begin send(2, 64'hFFFFFFFFFFFFFFFF); send(2, 64'h0000000000000000); end
    join
    repeat (80) @(posedge clk);
    #1;

    send(0, 64'hDB6DB6DB6DB6DB6D);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(0, 64'h8000000000000000);
    repeat (80) @(posedge clk);
    #1;

    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
    join
    repeat (100) @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) chk("drained", i, sbq[i].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
